// File: rtl/isb_pkg.sv
// Shared types and default widths for the ISB training unit and its pair FIFO.
// Optional ISB_TU_PAIR_DEDUP_EN adds per-entry last-pair storage to the entry type.
package isb_pkg;

    localparam int PC_W       = 16;
    localparam int ADDR_W     = 16;
    localparam int TU_ENTRIES = 4;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] next;
    } tu_pair_t;

    typedef struct packed {
        logic                          valid;
        logic [PC_W-1:0]               tag;
        logic [ADDR_W-1:0]             last;
        logic [$clog2(TU_ENTRIES)-1:0] age;
`ifdef ISB_TU_PAIR_DEDUP_EN
        logic                          lp_valid;
        tu_pair_t                      last_pair;
`endif
    } tu_entry_t;

endpackage

// File: rtl/isb_pair_fifo.sv
// Synchronous pair FIFO; a push into a full FIFO succeeds only when a pop happens on the same edge.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module isb_pair_fifo
    import isb_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type pair_t = tu_pair_t,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  pair_t       din,
    output pair_t       dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    pair_t       mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // storage carries data only, so it is never cleared
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/isb_training_unit.sv
// PC-localised ISB training unit: per-PC last-address table with age-counter LRU, emitting (prev, next) pairs into a FIFO.
// Define ISB_TU_PAIR_DEDUP_EN to suppress a pair identical to the last one its entry emitted.
module isb_training_unit
    import isb_pkg::*;
#(
    parameter int PC_W       = isb_pkg::PC_W,
    parameter int ADDR_W     = isb_pkg::ADDR_W,
    parameter int TU_ENTRIES = 4,
    parameter int Q_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_in,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_prev,
    output logic [ADDR_W-1:0] out_next,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int IDX_W = $clog2(TU_ENTRIES);
    localparam int CNT_W = $clog2(Q_DEPTH) + 1;
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(TU_ENTRIES - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] next;
    } pair_t;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   tag;
        logic [ADDR_W-1:0] last;
        logic [IDX_W-1:0]  age;
`ifdef ISB_TU_PAIR_DEDUP_EN
        logic              lp_valid;
        pair_t             last_pair;
`endif
    } entry_t;

    entry_t           tbl [TU_ENTRIES];
    logic             hit;
    logic             free_found;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] lru_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] acc_age;
    pair_t            new_pair;
    logic             pair_gen;
    logic             push_p0;
    logic             drop_p0;
    pair_t            head;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;

    // Invalid entries sit at the maximum age, so allocating one ages every valid entry
    // and the ages stay a permutation once the table is full.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        lru_idx    = '0;
        for (int i = 0; i < TU_ENTRIES; i++) begin
            if (!hit && tbl[i].valid && (tbl[i].tag == pc)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free_found && !tbl[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (tbl[i].age == AGE_MAX) lru_idx = IDX_W'(i);
        end
    end

    assign sel_idx  = hit ? hit_idx : (free_found ? free_idx : lru_idx);
    assign acc_age  = tbl[sel_idx].age;
    assign new_pair = '{prev: tbl[hit_idx].last, next: addr};
    assign pair_gen = v_in && hit && (tbl[hit_idx].last != addr);

`ifdef ISB_TU_PAIR_DEDUP_EN
    assign push_p0 = pair_gen &&
                     !(tbl[hit_idx].lp_valid && (tbl[hit_idx].last_pair == new_pair));
`else
    assign push_p0 = pair_gen;
`endif

    assign drop_p0 = push_p0 && q_full && !out_ready;

    // stage p0 -> FIFO: table, LRU and pair push all commit on this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TU_ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].age   <= AGE_MAX;
`ifdef ISB_TU_PAIR_DEDUP_EN
                tbl[i].lp_valid <= 1'b0;
`endif
            end
        end else if (v_in) begin
            for (int i = 0; i < TU_ENTRIES; i++) begin
                if (IDX_W'(i) == sel_idx) begin
                    tbl[i].age  <= '0;
                    tbl[i].last <= addr;
                    if (!hit) begin
                        tbl[i].valid <= 1'b1;
                        tbl[i].tag   <= pc;
`ifdef ISB_TU_PAIR_DEDUP_EN
                        tbl[i].lp_valid <= 1'b0;
                    end else if (push_p0) begin
                        tbl[i].lp_valid  <= 1'b1;
                        tbl[i].last_pair <= new_pair;
`endif
                    end
                end else if (tbl[i].age < acc_age) begin
                    tbl[i].age <= tbl[i].age + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_p0 && (drop_cnt != DROP_CNT_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    isb_pair_fifo #(
        .DEPTH  (Q_DEPTH),
        .pair_t (pair_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_p0),
        .pop   (out_ready),
        .din   (new_pair),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign out_valid = !q_empty;
    assign out_prev  = head.prev;
    assign out_next  = head.next;
    assign busy      = (q_count != '0);

endmodule

// File: tb/tb_isb_training_unit.sv
// Bench for isb_training_unit: directed scenarios with literal pair lists plus a randomized run,
// all checked every cycle against a queue/list based behavioural model.
module tb_isb_training_unit;

    localparam int TU = 4;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_in;
    logic [15:0] pc;
    logic [15:0] addr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_prev;
    logic [15:0] out_next;
    logic [15:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    isb_training_unit #(
        .PC_W       (16),
        .ADDR_W     (16),
        .TU_ENTRIES (TU),
        .Q_DEPTH    (QD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .v_in      (v_in),
        .pc        (pc),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prev  (out_prev),
        .out_next  (out_next),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: table slots, recency list (MRU first), pair queue, drop count.
    bit          m_valid [TU];
    logic [15:0] m_tag   [TU];
    logic [15:0] m_last  [TU];
    int          lru[$];
    logic [31:0] q[$];
    int          m_drop = 0;
    bit          chk_en = 1'b0;
    logic [31:0] plog[$];
    logic [31:0] ex[$];

    bit          gen;
    bit          pop;
    int          h;
    int          s;
    logic [31:0] np;

    function automatic void touch(input int slot);
        for (int k = 0; k < lru.size(); k++) begin
            if (lru[k] == slot) begin
                lru.delete(k);
                break;
            end
        end
        lru.push_front(slot);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TU; k++) m_valid[k] = 1'b0;
            lru.delete();
            q.delete();
            m_drop = 0;
        end else begin
            gen = 1'b0;
            np  = '0;
            pop = (q.size() != 0) && out_ready;
            if (v_in) begin
                h = -1;
                for (int k = 0; k < TU; k++)
                    if (m_valid[k] && m_tag[k] == pc) h = k;
                if (h >= 0) begin
                    if (m_last[h] != addr) begin
                        gen = 1'b1;
                        np  = {m_last[h], addr};
                    end
                    m_last[h] = addr;
                    touch(h);
                end else begin
                    s = -1;
                    for (int k = TU - 1; k >= 0; k--)
                        if (!m_valid[k]) s = k;
                    if (s < 0) s = lru[$];
                    m_valid[s] = 1'b1;
                    m_tag[s]   = pc;
                    m_last[s]  = addr;
                    touch(s);
                end
            end
            if (pop) void'(q.pop_front());
            if (gen) begin
                if (q.size() < QD) q.push_back(np);
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("out_prev", {16'd0, out_prev}, (q.size() != 0) ? {16'd0, q[0][31:16]} : 32'd0);
            chk("out_next", {16'd0, out_next}, (q.size() != 0) ? {16'd0, q[0][15:0]} : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
            if (out_valid && out_ready) plog.push_back({out_prev, out_next});
        end
    end

    task automatic apply(input bit r, input bit v, input logic [15:0] p, input logic [15:0] a,
                         input bit rdy);
        reset     = r;
        v_in      = v;
        pc        = p;
        addr      = a;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++)
            apply(1'b0, 1'b0, 16'($urandom), 16'($urandom), rdy);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        apply(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, plog.size(), ex.size());
        for (int k = 0; k < ex.size(); k++)
            chk(name, (k < plog.size()) ? plog[k] : 32'hDEAD_BEEF, ex[k]);
    endtask

    initial begin
        reset = 1'b1; v_in = 1'b0; pc = '0; addr = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_out_prev", {16'd0, out_prev}, 32'd0);

        // single-PC stream
        plog.delete();
        apply(0, 1, 16'h0, 16'h10, 1);
        apply(0, 1, 16'h0, 16'h11, 1);
        apply(0, 1, 16'h0, 16'h12, 1);
        apply(0, 1, 16'h0, 16'h11, 1);
        apply(0, 1, 16'h0, 16'h12, 1);
        apply(0, 1, 16'h0, 16'h11, 1);
        idle(3, 1);
        ex = '{32'h0010_0011, 32'h0011_0012, 32'h0012_0011, 32'h0011_0012, 32'h0012_0011};
        chk_log("single_pc");
        chk("single_drop", {16'd0, drop_cnt}, 32'd0);

        // repeat suppression
        do_reset();
        plog.delete();
        apply(0, 1, 16'h0, 16'h20, 1);
        apply(0, 1, 16'h0, 16'h20, 1);
        apply(0, 1, 16'h0, 16'h21, 1);
        idle(3, 1);
        ex = '{32'h0020_0021};
        chk_log("repeat");

        // replacement: PC 2 becomes LRU after PC 1 is re-touched, PC 5 evicts it
        do_reset();
        plog.delete();
        for (int p = 1; p <= 4; p++) apply(0, 1, 16'(p), 16'(16'h100 + p), 1);
        apply(0, 1, 16'h1, 16'h101, 1);
        apply(0, 1, 16'h5, 16'h105, 1);
        apply(0, 1, 16'h2, 16'h202, 1);
        apply(0, 1, 16'h1, 16'h1AA, 1);
        idle(3, 1);
        ex = '{32'h0101_01AA};
        chk_log("replace");

        // backpressure and overflow
        do_reset();
        plog.delete();
        apply(0, 1, 16'h7, 16'h0, 0);
        for (int a = 1; a <= 6; a++) apply(0, 1, 16'h7, 16'(a), 0);
        chk("ovf_valid", {31'd0, out_valid}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        chk("ovf_drop", {16'd0, drop_cnt}, 32'd2);
        idle(4, 1);
        ex = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003, 32'h0003_0004};
        chk_log("drain");
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // push and pop on the same edge while full
        for (int a = 7; a <= 10; a++) apply(0, 1, 16'h7, 16'(a), 0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        plog.delete();
        apply(0, 1, 16'h7, 16'd11, 1);
        chk("pp_drop", {16'd0, drop_cnt}, 32'd2);
        chk("pp_busy", {31'd0, busy}, 32'd1);
        idle(5, 1);
        ex = '{32'h0006_0007, 32'h0007_0008, 32'h0008_0009, 32'h0009_000A, 32'h000A_000B};
        chk_log("full_pushpop");

        // reset with pairs queued and an access in flight
        apply(0, 1, 16'h9, 16'h50, 0);
        apply(0, 1, 16'h9, 16'h51, 0);
        apply(0, 1, 16'h9, 16'h52, 0);
        apply(0, 1, 16'h9, 16'h53, 0);
        apply(1, 1, 16'h9, 16'h55, 0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        plog.delete();
        apply(0, 1, 16'h9, 16'h66, 1);
        idle(3, 1);
        ex.delete();
        chk_log("post_reset");

        // randomized traffic with occasional reset and frequent backpressure
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                  16'($urandom_range(0, 5)), 16'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0);
        end
        idle(8, 1);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
